systolic_n_body_force_collector: RTL
====================================

# systolic_n_body_force_collector

Drain-side companion to the systolic n-body array. It accepts per-block partial force sums from the array edges: row sums (right edge) and column sums (bottom edge, already negated by the cells). It accumulates them per body across all blocks of one timestep. At end of timestep it streams one accumulated force per body, in index order, to the Verlet integration stage over a valid/ready handshake. It sits between the 2x2 cell array and the integration module.

## Interface
- N_BODIES, default 8: number of bodies. Even, 2..256.
- WIDTH, default 32: signed two's-complement fixed-point width of force values.
- IDX_W, default $clog2(N_BODIES): body index width.

- clk  in  1  sole clock; all state on posedge.
- reset  in  1  asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
- in_valid  in  1  partial-sum beat present.
- in_ready  out  1  collector accepts beats; high only in ACCUM.
- in_i_base  in  IDX_W  body index of block row lane 0; LSB ignored (treated as 0).
- in_j_base  in  IDX_W  body index of block column lane 0; LSB ignored.
- in_p_right0, in_p_right1  in  WIDTH  row partial sums for bodies i_base, i_base+1.
- in_p_down0, in_p_down1  in  WIDTH  column partial sums for bodies j_base, j_base+1.
- in_last  in  1  beat is the final block of the timestep.
- out_valid  out  1  out_idx/out_force hold a result.
- out_ready  in  1  integration stage consumes the result.
- out_idx  out  IDX_W  body index of out_force.
- out_force  out  WIDTH  accumulated force for body out_idx.
- out_last  out  1  high with the result for body N_BODIES-1.

## Operation
- Storage: acc[0..N_BODIES-1], WIDTH each. Cleared on reset.
- States:
  - ACCUM (reset state).
  - DRAIN_LOAD.
  - DRAIN.
- ACCUM, beat accepted (in_valid && in_ready):
  - Off-diagonal (i_base != j_base):
    - acc[i+k] += p_right[k].
    - acc[j+k] += p_down[k], for k = 0, 1.
  - Diagonal (i_base == j_base): acc[i+k] += p_right[k] + p_down[k]. This is a single combined update with no lost write.
  - Any lane whose index is >= N_BODIES is ignored.
  - All additions saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The diagonal three-operand sum saturates once, on the final result.
  - If in_last is set: the accepted beat is still accumulated, then next state is DRAIN_LOAD with drain pointer = 0.
- DRAIN_LOAD:
  - out_force <= acc[ptr], out_idx <= ptr, out_last <= (ptr == N_BODIES-1).
  - out_valid <= 1, acc[ptr] <= 0.
  - Next state: DRAIN.
- DRAIN:
  - Outputs are held while out_ready = 0.
  - On handshake with out_last = 0: ptr + 1, next state DRAIN_LOAD.
  - On handshake with out_last = 1: out_valid <= 0, next state ACCUM.
- in_valid is ignored outside ACCUM. in_ready = (state == ACCUM).
- Accumulators are zero after drain, so the next timestep starts clean with no explicit clear cycle.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid, out_last = 0.
  - out_idx, out_force = 0.
  - all acc = 0.
  - state = ACCUM.
- Accumulation latency is 1 cycle. Back-to-back beats, including beats hitting the same body, accumulate correctly every cycle.
- Last beat accepted at edge E:
  - in_ready falls after E.
  - out_valid rises after edge E+1, with out_idx = 0 carrying the last beat's contribution.
- Drain throughput is one result per 2 cycles, because DRAIN_LOAD is interleaved. Full drain takes 2*N_BODIES cycles with out_ready held high.
- in_ready returns high the cycle after the out_last handshake.
- Reset mid-drain or mid-accumulation:
  - out_valid drops immediately (asynchronous).
  - Partial sums and the partial drain are discarded.
  - No output is produced for that timestep.

## Test plan
- Reset: hold reset = 0 with in_valid = 1. Required: in_ready = 1, out_valid = 0, out_force = 0. After release, a drain with no prior beats (single zero beat with in_last) yields four zeros (N_BODIES = 4).
- Off-diagonal block (N_BODIES = 4, WIDTH = 16): i_base = 0, j_base = 2, right = {5, -3}, down = {-5, 3}, in_last = 1. Required: drain yields (0, 5), (1, -3), (2, -5), (3, 3), with out_last on idx 3.
- Diagonal block: i_base = j_base = 0, right = {1, 2}, down = {10, 20}, followed by a zero beat with in_last. Required: out_force for idx 0 = 11, idx 1 = 22.
- Saturation (WIDTH = 16): two consecutive beats with right0 = 30000 to body 0. Required: out_force = 32767. Repeat with -30000; required: -32768.
- Backpressure: hold out_ready low for 3 cycles at idx 1. Required: out_idx and out_force held stable; in_ready = 0 for the whole drain; in_valid pulses have no effect. Next timestep's first beat of 7 to body 1 yields 7, not 7 + old.
- Reset pulse after the idx 1 handshake: out_valid = 0 asynchronously. Next timestep with right0 = 4 to body 0 drains 4, 0, 0, 0.

Source files
------------

// File: rtl/systolic_n_body_force_collector.sv
// Drain-side force collector for the systolic n-body array.
// Accumulates per-body row/column partial sums over one timestep, then
// streams one saturated force per body, in index order, over valid/ready.
module systolic_n_body_force_collector #(
   parameter int N_BODIES = 8,
   parameter int WIDTH    = 32,
   parameter int IDX_W    = $clog2(N_BODIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_i_base,
   input  logic [IDX_W-1:0] in_j_base,
   input  logic [WIDTH-1:0] in_p_right0,
   input  logic [WIDTH-1:0] in_p_right1,
   input  logic [WIDTH-1:0] in_p_down0,
   input  logic [WIDTH-1:0] in_p_down1,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] out_force,
   output logic             out_last
);

   typedef enum logic [1:0] {ACCUM, DRAIN_LOAD, DRAIN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);

   state_t                  state_q;
   logic [IDX_W-1:0]        ptr_q;
   logic signed [WIDTH-1:0] acc_q [N_BODIES];
   logic signed [WIDTH-1:0] acc_d [N_BODIES];
   logic                    out_valid_q;
   logic                    out_last_q;
   logic [IDX_W-1:0]        out_idx_q;
   logic signed [WIDTH-1:0] out_force_q;

   // Clamp a two-bit-extended sum back into the WIDTH-bit signed range.
   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+1:0] x);
      if (x[WIDTH+1:WIDTH-1] == 3'b000 || x[WIDTH+1:WIDTH-1] == 3'b111)
         return x[WIDTH-1:0];
      else if (x[WIDTH+1])
         return {1'b1, {(WIDTH-1){1'b0}}};
      else
         return {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   // Candidate accumulator values for the current beat: every body sums the
   // lanes that address it and saturates once, so a diagonal block (row and
   // column hitting the same body) folds into one update.
   always_comb begin
      logic [WIDTH+1:0] sum;
      logic [WIDTH-1:0] rv;
      logic [WIDTH-1:0] dv;
      logic             hit_r;
      logic             hit_d;
      sum   = '0;
      rv    = '0;
      dv    = '0;
      hit_r = 1'b0;
      hit_d = 1'b0;
      for (int b = 0; b < N_BODIES; b++) begin
         hit_r = (b >> 1) == (int'(in_i_base) >> 1);
         hit_d = (b >> 1) == (int'(in_j_base) >> 1);
         rv    = (b % 2 == 1) ? in_p_right1 : in_p_right0;
         dv    = (b % 2 == 1) ? in_p_down1  : in_p_down0;
         sum   = {{2{acc_q[b][WIDTH-1]}}, acc_q[b]};
         if (hit_r) sum = sum + {{2{rv[WIDTH-1]}}, rv};
         if (hit_d) sum = sum + {{2{dv[WIDTH-1]}}, dv};
         acc_d[b] = (hit_r || hit_d) ? sat(sum) : acc_q[b];
      end
   end

   // Control FSM with registered drain outputs and accumulator storage.
   // The drain slot clears its accumulator as it is read, so the next
   // timestep starts from zero without a dedicated clear pass.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACCUM;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         out_force_q <= '0;
         for (int b = 0; b < N_BODIES; b++) acc_q[b] <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  acc_q <= acc_d;
                  if (in_last) begin
                     ptr_q   <= '0;
                     state_q <= DRAIN_LOAD;
                  end
               end
            end
            DRAIN_LOAD: begin
               out_force_q   <= acc_q[ptr_q];
               out_idx_q     <= ptr_q;
               out_last_q    <= (ptr_q == LAST_IDX);
               out_valid_q   <= 1'b1;
               acc_q[ptr_q]  <= '0;
               state_q       <= DRAIN;
            end
            DRAIN: begin
               // Valid drops on every handshake so the load slot never
               // presents an already-consumed result a second time.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (out_last_q) begin
                     state_q <= ACCUM;
                  end else begin
                     ptr_q   <= ptr_q + 1'b1;
                     state_q <= DRAIN_LOAD;
                  end
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_idx   = out_idx_q;
   assign out_force = out_force_q;

endmodule
